pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Generates the instruction-address stream for the fetcher. It issues one PC at a time and waits for the fetcher to return that PC's instruction. It predecodes the instruction: JAL targets are computed directly, and conditional branches are predicted with a 256-entry 2-bit BHT. It sends the next PC together with the prediction bit for the previous instruction. It sits between the branch-resolution/flush logic and the fetcher.

## Interface
Parameters:
- RESET_PC, 32'h0, first PC issued after reset.
- BHT_SIZE, 256, BHT entries; index = pc[9:2].

Ports:
- in_clk  input  1  clock; all state changes on rising edge.
- in_rst  input  1  synchronous, active-low reset; 0 = reset.
- in_rdy  input  1  global ready; when 0, all state holds and outputs hold.
- in_flush_enable  input  1  misprediction flush from commit.
- in_flush_pc  input  32  correct PC to resume from.
- in_bht_enable  input  1  branch resolved; update BHT.
- in_bht_pc  input  32  PC of the resolved branch.
- in_bht_taken  input  1  actual direction.
- in_fetch_full  input  1  fetcher queue full; no issue while 1.
- in_last_enable  input  1  fetcher returns an instruction.
- in_last_pc  input  32  PC of the returned instruction.
- in_last_inst  input  32  returned instruction.
- out_fetcher_enable  output  1  one-cycle pulse: push out_fetcher_pc.
- out_fetcher_pc  output  32  PC to fetch.
- out_fetcher_predict  output  1  prediction for the previously issued PC; 1 = taken.

## Operation
- Registers: cur_pc (32), pend_predict (1), state ∈ {ISSUE, WAIT}, bht[256] of 2-bit counters.
- Reset (in_rst=0):
  - state=ISSUE, cur_pc=RESET_PC, pend_predict=0.
  - Outputs: out_fetcher_enable=0, out_fetcher_pc=RESET_PC, out_fetcher_predict=0.
  - All BHT counters = 2'b01 (weakly not-taken).
- ISSUE:
  - If in_fetch_full=0: out_fetcher_enable<=1, out_fetcher_pc<=cur_pc, out_fetcher_predict<=pend_predict, state<=WAIT.
  - Otherwise out_fetcher_enable<=0 and stay in ISSUE.
- WAIT:
  - out_fetcher_enable<=0.
  - On in_last_enable=1 with in_last_pc==cur_pc, predecode opcode = in_last_inst[6:0]:
    - 1101111 (JAL): next = cur_pc + sext(immJ), predict=1.
    - 1100011 (branch): c = bht[cur_pc[9:2]]. If c[1]=1: next = cur_pc + sext(immB), predict=1. Else next = cur_pc+4, predict=0.
    - Anything else, including JALR: next = cur_pc+4, predict=0. JALR is corrected by flush.
    - Then cur_pc<=next, pend_predict<=predict, state<=ISSUE.
  - in_last_enable with in_last_pc≠cur_pc is stale; ignore it.
- Immediates, sign-extended to 32 bits:
  - immB = {i[31], i[7], i[30:25], i[11:8], 0}.
  - immJ = {i[31], i[19:12], i[20], i[30:21], 0}.
  - All adds are modulo 2^32; wrap-around is not trapped.
- Flush (in_flush_enable=1, in_rdy=1):
  - cur_pc<=in_flush_pc, pend_predict<=0, state<=ISSUE, out_fetcher_enable<=0.
  - Overrides a same-cycle in_last_enable and ISSUE.
- BHT update (in_bht_enable=1, in_rdy=1): a 2-bit saturating counter at in_bht_pc[9:2].
  - Taken increments, saturating at 11.
  - Not-taken decrements, saturating at 00.
  - Applied independently of flush; it also happens in a flush cycle.
- Simultaneous BHT update and predecode lookup of the same index: the lookup uses the pre-update counter value.

## Timing
- Issue latency: out_fetcher_enable rises the cycle after the ISSUE cycle in which in_fetch_full=0.
  - From reset release, the first pulse appears on edge 1.
- Return-to-issue: in_last_enable sampled at edge N → state ISSUE after N → pulse for the next PC at edge N+1 if not full.
  - At most one PC is outstanding.
- out_fetcher_enable is never high on two consecutive cycles.
- Flush at edge N: the first post-flush pulse, carrying in_flush_pc, is at edge N+1 if not full.
- in_rdy=0: no register changes, BHT included; outputs hold their values, including a high out_fetcher_enable.

## Test plan
- Reset with RESET_PC=0, fetch not full → pulse at cycle 1: pc=0x0, predict=0. No further pulse until in_last_enable(pc=0, inst=NOP).
- Return JAL x0,+16 (0x0100006F) at pc 0x0 → next pulse pc=0x10, predict=1.
- Branch BEQ +8 at pc 0x20 with BHT reset state → pc=0x24, predict=0. Then two in_bht_enable taken updates for 0x20, reissue 0x20 → next pc=0x28, predict=1.
- Saturation: five taken updates at idx 5 → counter 11; one not-taken → 10, still predicts taken. Four not-taken → 00.
- Flush to 0x100 in the same cycle as a matching in_last_enable → next pulse pc=0x100, predict=0. The returned instruction is ignored.
- in_fetch_full=1 for 3 cycles in ISSUE → no pulse. Full deasserts → pulse on the following edge. Stale in_last_pc mismatch in WAIT → no state change.

Source files
------------

// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl
//
// Instruction-address generator sitting between branch resolution / flush
// logic and the fetcher. One PC is outstanding at a time: the block issues a
// PC, waits for the fetcher to hand back that PC's instruction, predecodes it
// and picks the next PC.
//
//   - JAL targets are computed directly from the J-immediate.
//   - Conditional branches are predicted by a table of 2-bit saturating
//     counters indexed by pc[IDX_W+1:2].
//   - Everything else (JALR included) falls through to pc+4; a wrong guess
//     is repaired later by a flush from commit.
//
// The prediction for an instruction travels with the *next* issued PC, so
// out_fetcher_predict qualifies the previously issued address.
//
// Parameters
//   RESET_PC  first PC issued after reset
//   BHT_SIZE  number of 2-bit counters (power of two)
//
// Ports
//   in_clk               clock, all state changes on the rising edge
//   in_rst               synchronous active-low reset
//   in_rdy               global ready; 0 freezes every register and output
//   in_flush_enable      misprediction flush from commit
//   in_flush_pc          PC to resume from after a flush
//   in_bht_enable        resolved branch, train the BHT
//   in_bht_pc            PC of the resolved branch
//   in_bht_taken         actual branch direction
//   in_fetch_full        fetcher queue full, hold off issuing
//   in_last_enable       fetcher returns an instruction
//   in_last_pc           PC of the returned instruction
//   in_last_inst         returned instruction word
//   out_fetcher_enable   one-cycle push strobe for out_fetcher_pc
//   out_fetcher_pc       PC to fetch
//   out_fetcher_predict  taken prediction for the previously issued PC
// -----------------------------------------------------------------------------
module pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          BHT_SIZE = 256
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_rdy,
  input  logic        in_flush_enable,
  input  logic [31:0] in_flush_pc,
  input  logic        in_bht_enable,
  input  logic [31:0] in_bht_pc,
  input  logic        in_bht_taken,
  input  logic        in_fetch_full,
  input  logic        in_last_enable,
  input  logic [31:0] in_last_pc,
  input  logic [31:0] in_last_inst,
  output logic        out_fetcher_enable,
  output logic [31:0] out_fetcher_pc,
  output logic        out_fetcher_predict
);

  localparam int IDX_W = $clog2(BHT_SIZE);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] CTR_RESET = 2'b01;  // weakly not-taken
  localparam logic [1:0] CTR_MAX   = 2'b11;
  localparam logic [1:0] CTR_MIN   = 2'b00;

  typedef enum logic {
    ST_ISSUE,
    ST_WAIT
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q,  state_d;
  logic [31:0] cur_pc_q, cur_pc_d;
  logic        pend_q,   pend_d;    // prediction for the last decoded PC

  logic        en_d;
  logic [31:0] pc_d;
  logic        pred_d;

  logic [1:0]  bht_q [BHT_SIZE];

  // ---------------------------------------------------------------------------
  // Predecode of the returned instruction
  // ---------------------------------------------------------------------------
  logic [6:0]       opcode;
  logic [31:0]      imm_b;
  logic [31:0]      imm_j;
  logic [IDX_W-1:0] cur_idx;
  logic             bht_says_taken;
  logic [31:0]      next_pc;
  logic             next_pred;

  assign opcode = in_last_inst[6:0];

  assign imm_b = {{20{in_last_inst[31]}}, in_last_inst[7], in_last_inst[30:25],
                  in_last_inst[11:8], 1'b0};

  assign imm_j = {{12{in_last_inst[31]}}, in_last_inst[19:12], in_last_inst[20],
                  in_last_inst[30:21], 1'b0};

  // Lookup reads the registered counter, so a same-cycle training write to
  // the same entry is not seen until the next lookup.
  assign cur_idx        = cur_pc_q[IDX_W+1:2];
  assign bht_says_taken = bht_q[cur_idx][1];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    next_pc   = cur_pc_q + 32'd4;
    next_pred = 1'b0;
    if (opcode == OP_JAL) begin
      next_pc   = cur_pc_q + imm_j;
      next_pred = 1'b1;
    end else if (opcode == OP_BRANCH && bht_says_taken) begin
      next_pc   = cur_pc_q + imm_b;
      next_pred = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue / wait FSM, next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cur_pc_d = cur_pc_q;
    pend_d   = pend_q;
    en_d     = out_fetcher_enable;
    pc_d     = out_fetcher_pc;
    pred_d   = out_fetcher_predict;

    // With in_rdy low everything keeps its value, including a high strobe.
    if (in_rdy) begin
      if (in_flush_enable) begin
        // Flush wins over both a pending issue and a same-cycle return.
        cur_pc_d = in_flush_pc;
        pend_d   = 1'b0;
        state_d  = ST_ISSUE;
        en_d     = 1'b0;
      end else begin
        unique case (state_q)
          ST_ISSUE: begin
            if (!in_fetch_full) begin
              en_d    = 1'b1;
              pc_d    = cur_pc_q;
              pred_d  = pend_q;
              state_d = ST_WAIT;
            end else begin
              en_d = 1'b0;
            end
          end
          ST_WAIT: begin
            en_d = 1'b0;
            // A return for any other PC belongs to a flushed request.
            if (in_last_enable && in_last_pc == cur_pc_q) begin
              cur_pc_d = next_pc;
              pend_d   = next_pred;
              state_d  = ST_ISSUE;
            end
          end
          default: state_d = ST_ISSUE;
        endcase
      end
    end
  end

  always_ff @(posedge in_clk) begin
    // NOTE: non-blocking assignments make every register sample the values
    // from before the edge, independent of statement order.
    if (!in_rst) begin
      state_q             <= ST_ISSUE;
      cur_pc_q            <= RESET_PC;
      pend_q              <= 1'b0;
      out_fetcher_enable  <= 1'b0;
      out_fetcher_pc      <= RESET_PC;
      out_fetcher_predict <= 1'b0;
    end else begin
      state_q             <= state_d;
      cur_pc_q            <= cur_pc_d;
      pend_q              <= pend_d;
      out_fetcher_enable  <= en_d;
      out_fetcher_pc      <= pc_d;
      out_fetcher_predict <= pred_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Branch history table training
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_old;
  logic [1:0]       upd_new;

  assign upd_idx = in_bht_pc[IDX_W+1:2];
  assign upd_old = bht_q[upd_idx];

  always_comb begin
    upd_new = upd_old;
    if (in_bht_taken) begin
      if (upd_old != CTR_MAX) upd_new = upd_old + 2'd1;
    end else begin
      if (upd_old != CTR_MIN) upd_new = upd_old - 2'd1;
    end
  end

  // Training is independent of flush: a resolved branch still counts even
  // when it is also the one that triggered the flush.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      // NOTE: the table is built from flops rather than a RAM macro, which is
      // what lets every entry start at a known value out of reset.
      for (int i = 0; i < BHT_SIZE; i++) begin
        bht_q[i] <= CTR_RESET;
      end
    end else if (in_rdy && in_bht_enable) begin
      bht_q[upd_idx] <= upd_new;
    end
  end

  // Only the index bits of the training PC select a counter.
  logic unused_bht_pc_bits;
  assign unused_bht_pc_bits = ^{in_bht_pc[31:IDX_W+2], in_bht_pc[1:0]};

endmodule

// File: tb/tb_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_ctrl
//
// Self-checking bench for pc_ctrl. A transaction-level reference model
// (integer counters, plain arithmetic for the immediates) predicts the three
// outputs after every rising edge; they are compared half a cycle later.
// A directed sequence walks the documented scenarios, then a randomized
// phase drives ready, flush, BHT training, back-pressure and a fetcher that
// answers with random delays, random instructions and stale PCs.
// -----------------------------------------------------------------------------
module tb_pc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_rdy;
  logic        in_flush_enable;
  logic [31:0] in_flush_pc;
  logic        in_bht_enable;
  logic [31:0] in_bht_pc;
  logic        in_bht_taken;
  logic        in_fetch_full;
  logic        in_last_enable;
  logic [31:0] in_last_pc;
  logic [31:0] in_last_inst;
  logic        out_fetcher_enable;
  logic [31:0] out_fetcher_pc;
  logic        out_fetcher_predict;

  pc_ctrl #(.RESET_PC(RESET_PC), .BHT_SIZE(256)) dut (
    .in_clk              (in_clk),
    .in_rst              (in_rst),
    .in_rdy              (in_rdy),
    .in_flush_enable     (in_flush_enable),
    .in_flush_pc         (in_flush_pc),
    .in_bht_enable       (in_bht_enable),
    .in_bht_pc           (in_bht_pc),
    .in_bht_taken        (in_bht_taken),
    .in_fetch_full       (in_fetch_full),
    .in_last_enable      (in_last_enable),
    .in_last_pc          (in_last_pc),
    .in_last_inst        (in_last_inst),
    .out_fetcher_enable  (out_fetcher_enable),
    .out_fetcher_pc      (out_fetcher_pc),
    .out_fetcher_predict (out_fetcher_predict)
  );

  always #5 in_clk = ~in_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit [31:0] m_pc;         // next address to hand out
  bit        m_pred;       // prediction that rides on the next pulse
  bit        m_waiting;    // one address outstanding
  bit        m_en;
  bit [31:0] m_out_pc;
  bit        m_out_pred;
  int        bht_m [256];

  function automatic int imm_b_of(input bit [31:0] i);
    int v = 0;
    if (i[31]) v -= 4096;
    v += int'(i[7])     * 2048;
    v += int'(i[30:25]) * 32;
    v += int'(i[11:8])  * 2;
    return v;
  endfunction

  function automatic int imm_j_of(input bit [31:0] i);
    int v = 0;
    if (i[31]) v -= (1 << 20);
    v += int'(i[19:12]) * 4096;
    v += int'(i[20])    * 2048;
    v += int'(i[30:21]) * 2;
    return v;
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    int ctr;
    if (!in_rst) begin
      m_pc = RESET_PC; m_pred = 0; m_waiting = 0;
      m_en = 0; m_out_pc = RESET_PC; m_out_pred = 0;
      foreach (bht_m[k]) bht_m[k] = 1;
      return;
    end
    if (!in_rdy) return;
    ctr = bht_m[m_pc[9:2]];
    if (in_flush_enable) begin
      m_pc = in_flush_pc; m_pred = 0; m_waiting = 0; m_en = 0;
    end else if (!m_waiting) begin
      m_en = !in_fetch_full;
      if (!in_fetch_full) begin
        m_out_pc = m_pc; m_out_pred = m_pred; m_waiting = 1;
      end
    end else begin
      m_en = 0;
      if (in_last_enable && in_last_pc == m_pc) begin
        if (in_last_inst[6:0] == 7'h6F) begin
          m_pc = m_pc + imm_j_of(in_last_inst); m_pred = 1;
        end else if (in_last_inst[6:0] == 7'h63 && ctr >= 2) begin
          m_pc = m_pc + imm_b_of(in_last_inst); m_pred = 1;
        end else begin
          m_pc = m_pc + 4; m_pred = 0;
        end
        m_waiting = 0;
      end
    end
    if (in_bht_enable) begin
      if (in_bht_taken) bht_m[in_bht_pc[9:2]] = (bht_m[in_bht_pc[9:2]] == 3) ? 3 : bht_m[in_bht_pc[9:2]] + 1;
      else              bht_m[in_bht_pc[9:2]] = (bht_m[in_bht_pc[9:2]] == 0) ? 0 : bht_m[in_bht_pc[9:2]] - 1;
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge in_clk);
    model_step();
    @(negedge in_clk);
    check("en",   {31'd0, out_fetcher_enable},  {31'd0, m_en});
    check("pc",   out_fetcher_pc,               m_out_pc);
    check("pred", {31'd0, out_fetcher_predict}, {31'd0, m_out_pred});
  endtask

  // ---------------------------------------------------------------------------
  // Directed helpers (expectations below are hand-derived constants)
  // ---------------------------------------------------------------------------
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] JAL_16  = 32'h0100_006F;  // jal x0, +16
  localparam logic [31:0] BEQ_8   = 32'h0000_0463;  // beq x0, x0, +8

  task automatic expect_pulse(input string tag, input logic [31:0] pc, input logic pred);
    check({tag, "_en"},   {31'd0, out_fetcher_enable},  32'd1);
    check({tag, "_pc"},   out_fetcher_pc,               pc);
    check({tag, "_pred"}, {31'd0, out_fetcher_predict}, {31'd0, pred});
  endtask

  // Flush to pc; the pulse for it follows on the next edge.
  task automatic issue_at(input logic [31:0] pc);
    in_flush_enable = 1; in_flush_pc = pc;
    tick();
    in_flush_enable = 0;
    tick();
    expect_pulse("issue", pc, 1'b0);
  endtask

  // Return inst for pc, then take the next pulse.
  task automatic ret(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                     input logic [31:0] exp_pc, input logic exp_pred);
    in_last_enable = 1; in_last_pc = pc; in_last_inst = inst;
    tick();
    in_last_enable = 0;
    tick();
    expect_pulse(tag, exp_pc, exp_pred);
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input int n);
    in_fetch_full = 1;
    in_bht_enable = 1; in_bht_pc = pc; in_bht_taken = taken;
    repeat (n) tick();
    in_bht_enable = 0; in_fetch_full = 0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom;
    logic [6:0]  op;
    case ($urandom % 5)
      0:       op = 7'h6F;
      1, 2:    op = 7'h63;
      3:       op = 7'h67;
      default: op = 7'h13;
    endcase
    return {r[31:7], op};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit        pend;
    bit [31:0] pend_pc;
    int        pend_dly;
    bit        real_ret;

    in_rst = 0; in_rdy = 1; in_flush_enable = 0; in_flush_pc = 0;
    in_bht_enable = 0; in_bht_pc = 0; in_bht_taken = 0; in_fetch_full = 0;
    in_last_enable = 0; in_last_pc = 0; in_last_inst = 0;

    @(negedge in_clk);
    tick(); tick();
    check("rst_en",   {31'd0, out_fetcher_enable},  32'd0);
    check("rst_pc",   out_fetcher_pc,               RESET_PC);
    check("rst_pred", {31'd0, out_fetcher_predict}, 32'd0);

    // First pulse on edge 1 after release, then silence while waiting.
    in_rst = 1;
    tick();
    expect_pulse("first", 32'h0, 1'b0);
    repeat (3) begin
      tick();
      check("hold_no_pulse", {31'd0, out_fetcher_enable}, 32'd0);
    end
    ret("nop0", 32'h0, NOP, 32'h4, 1'b0);

    // JAL at 0 -> 0x10, predicted taken.
    issue_at(32'h0);
    ret("jal", 32'h0, JAL_16, 32'h10, 1'b1);

    // BEQ with reset counter -> fall-through; after two taken updates -> target.
    issue_at(32'h20);
    ret("beq_cold", 32'h20, BEQ_8, 32'h24, 1'b0);
    train(32'h20, 1'b1, 2);
    issue_at(32'h20);
    ret("beq_warm", 32'h20, BEQ_8, 32'h28, 1'b1);

    // Saturation on index 5 (pc 0x14).
    train(32'h14, 1'b1, 5);
    issue_at(32'h14);
    ret("sat_hi", 32'h14, BEQ_8, 32'h1C, 1'b1);
    train(32'h14, 1'b0, 1);
    issue_at(32'h14);
    ret("sat_10", 32'h14, BEQ_8, 32'h1C, 1'b1);
    train(32'h14, 1'b0, 4);
    train(32'h14, 1'b1, 1);  // from 00 lands on 01: still not taken
    issue_at(32'h14);
    ret("sat_lo", 32'h14, BEQ_8, 32'h18, 1'b0);

    // Flush wins over a matching return in the same cycle.
    issue_at(32'h40);
    in_last_enable = 1; in_last_pc = 32'h40; in_last_inst = JAL_16;
    in_flush_enable = 1; in_flush_pc = 32'h100;
    tick();
    in_last_enable = 0; in_flush_enable = 0;
    tick();
    expect_pulse("flush", 32'h100, 1'b0);

    // Back-pressure in ISSUE.
    issue_at(32'h200);
    in_last_enable = 1; in_last_pc = 32'h200; in_last_inst = NOP; in_fetch_full = 1;
    tick();
    in_last_enable = 0;
    repeat (3) begin
      tick();
      check("full_no_pulse", {31'd0, out_fetcher_enable}, 32'd0);
    end
    in_fetch_full = 0;
    tick();
    expect_pulse("full_rel", 32'h204, 1'b0);

    // Stale return is ignored.
    in_last_enable = 1; in_last_pc = 32'h300; in_last_inst = JAL_16;
    repeat (2) begin
      tick();
      check("stale_no_pulse", {31'd0, out_fetcher_enable}, 32'd0);
    end
    ret("after_stale", 32'h204, NOP, 32'h208, 1'b0);

    // in_rdy low holds a high strobe and all state.
    in_rdy = 0;
    repeat (2) tick();
    expect_pulse("rdy_hold", 32'h208, 1'b0);
    in_rdy = 1;

    // -------------------------------------------------------------------------
    // Randomized phase
    // -------------------------------------------------------------------------
    pend = 1; pend_pc = 32'h208; pend_dly = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      in_rdy          = ($urandom % 8) != 0;
      in_fetch_full   = ($urandom % 5) == 0;
      in_flush_enable = ($urandom % 40) == 0;
      in_flush_pc     = $urandom & 32'hFFFF_FFFC;
      in_bht_enable   = ($urandom % 3) == 0;
      in_bht_pc       = (($urandom % 2) == 0) ? m_pc : ($urandom & 32'hFFFF_FFFC);
      in_bht_taken    = $urandom % 2;
      in_last_enable  = 0;
      real_ret        = 0;
      if (pend && pend_dly == 0) begin
        in_last_enable = 1;
        in_last_inst   = rand_inst();
        if (($urandom % 8) == 0) in_last_pc = pend_pc + 32'd8;
        else begin
          in_last_pc = pend_pc;
          real_ret   = 1;
        end
      end else if (($urandom % 16) == 0) begin
        in_last_enable = 1;
        in_last_pc     = $urandom & 32'hFFFF_FFFC;
        in_last_inst   = rand_inst();
      end
      tick();
      if (real_ret && in_rdy) pend = 0;
      if (pend_dly > 0) pend_dly--;
      if (m_en && in_rdy) begin
        pend = 1; pend_pc = m_out_pc; pend_dly = $urandom % 4;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
